// File: rtl/cache_ctrl_pkg.sv
// Shared types for the cache controller: state encodings visible on the state port.
package cache_ctrl_pkg;

    localparam logic [2:0] IDLE_CODE  = 3'd0;
    localparam logic [2:0] DONE_CODE  = 3'd5;
    localparam logic [2:0] ERROR_CODE = 3'd6;

    typedef enum logic [2:0] {
        IDLE      = IDLE_CODE,
        COMPARE   = 3'd1,
        WRITE     = 3'd2,
        WRITEBACK = 3'd3,
        ALLOCATE  = 3'd4,
        DONE      = DONE_CODE,
        ERROR     = ERROR_CODE
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Cache controller FSM: sequences tag compare, dirty eviction, line fill and
// write-back/write-through stores for one CPU request at a time.
module cache_ctrl_fsm
    import cache_ctrl_pkg::*;
#(
    parameter bit WRITE_BACK = 1'b1,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             rw,
    input  logic             hit,
    input  logic             dirty,
    input  logic             mem_ack,
    input  logic             cnt_clr,
    output logic             mem_req,
    output logic             mem_we,
    output logic             fill_en,
    output logic             write_en,
    output logic             set_dirty,
    output logic             data_ready,
    output logic             err,
    output logic             busy,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

    state_t           state_q, state_d;
    logic             rw_q, rw_d;
    logic             first_q, first_d;
    logic             entry_q;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             waiting;
    logic             timed_out;
    logic             hit_inc, miss_inc;

    // Any state that holds mem_req is waiting on memory and subject to the timeout.
    assign waiting   = (state_q == WRITEBACK) || (state_q == ALLOCATE) ||
                       ((state_q == WRITE) && !WRITE_BACK);
    assign timed_out = (TIMEOUT > 0) && !mem_ack && (tmo_q == TMO_LAST);

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        first_d    = first_q;
        tmo_d      = tmo_q;
        mem_req    = waiting;
        mem_we     = (state_q == WRITEBACK) || ((state_q == WRITE) && !WRITE_BACK);
        fill_en    = (state_q == ALLOCATE) && mem_ack;
        write_en   = (state_q == WRITE) && entry_q;
        set_dirty  = WRITE_BACK && (state_q == WRITE) && entry_q;
        data_ready = (state_q == DONE);
        err        = (state_q == ERROR);
        busy       = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = COMPARE;
                    rw_d    = rw;
                    first_d = 1'b1;
                end
            end
            COMPARE: begin
                if (hit) begin
                    state_d = rw_q ? WRITE : DONE;
                end else if (!first_q) begin
                    state_d = ERROR;
                end else if (WRITE_BACK) begin
                    state_d = dirty ? WRITEBACK : ALLOCATE;
                end else begin
                    state_d = rw_q ? WRITE : ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (mem_ack) state_d = ALLOCATE;
                else if (timed_out) state_d = ERROR;
            end
            ALLOCATE: begin
                if (mem_ack) begin
                    state_d = COMPARE;
                    first_d = 1'b0;
                end else if (timed_out) begin
                    state_d = ERROR;
                end
            end
            WRITE: begin
                if (WRITE_BACK || mem_ack) state_d = DONE;
                else if (timed_out) state_d = ERROR;
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (waiting && !mem_ack) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    // entry_q marks the first cycle spent in a state, used for the one-shot write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            first_q <= 1'b0;
            entry_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            first_q <= first_d;
            entry_q <= (state_d != state_q);
            tmo_q   <= tmo_d;
        end
    end

    assign state    = state_q;
    assign hit_inc  = (state_q == COMPARE) && first_q && hit;
    assign miss_inc = (state_q == COMPARE) && first_q && !hit;

    sat_counter #(.WIDTH(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hit_inc),
        .clr   (cnt_clr),
        .count (hit_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (miss_inc),
        .clr   (cnt_clr),
        .count (miss_cnt)
    );

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench: unit A is write-back with 2-bit counters, unit B is write-through.
module tb_cache_ctrl_fsm;

    logic clk;
    logic reset;
    logic selB;
    logic runIn, rwIn, hitIn, dirtyIn, ackIn, clrIn;
    logic runA, runB, clrA, clrB;

    logic       memReqA, memWeA, fillEnA, writeEnA, setDirtyA, dataReadyA, errA, busyA;
    logic [2:0] stateA;
    logic [1:0] hitCntA, missCntA;

    logic        memReqB, memWeB, fillEnB, writeEnB, setDirtyB, dataReadyB, errB, busyB;
    logic [2:0]  stateB;
    logic [15:0] hitCntB, missCntB;

    int checkCount;
    int passCount;

    assign runA = runIn & ~selB;
    assign runB = runIn & selB;
    assign clrA = clrIn & ~selB;
    assign clrB = clrIn & selB;

    cache_ctrl_fsm #(.WRITE_BACK(1'b1), .TIMEOUT(4), .CNT_W(2)) dutA (
        .clk(clk), .reset(reset), .run(runA), .rw(rwIn), .hit(hitIn), .dirty(dirtyIn),
        .mem_ack(ackIn), .cnt_clr(clrA), .mem_req(memReqA), .mem_we(memWeA),
        .fill_en(fillEnA), .write_en(writeEnA), .set_dirty(setDirtyA),
        .data_ready(dataReadyA), .err(errA), .busy(busyA), .state(stateA),
        .hit_cnt(hitCntA), .miss_cnt(missCntA)
    );

    cache_ctrl_fsm #(.WRITE_BACK(1'b0), .TIMEOUT(4), .CNT_W(16)) dutB (
        .clk(clk), .reset(reset), .run(runB), .rw(rwIn), .hit(hitIn), .dirty(dirtyIn),
        .mem_ack(ackIn), .cnt_clr(clrB), .mem_req(memReqB), .mem_we(memWeB),
        .fill_en(fillEnB), .write_en(writeEnB), .set_dirty(setDirtyB),
        .data_ready(dataReadyB), .err(errB), .busy(busyB), .state(stateB),
        .hit_cnt(hitCntB), .miss_cnt(missCntB)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic w, input logic h,
                                 input logic d, input logic a);
        runIn   = r;
        rwIn    = w;
        hitIn   = h;
        dirtyIn = d;
        ackIn   = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk        = 1'b0;
        reset      = 1'b1;
        selB       = 1'b0;
        clrIn      = 1'b0;
        checkCount = 0;
        passCount  = 0;
        applyStimulus(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_state", 32'(stateA), 0);
        checkOutput("rst_memreq", 32'(memReqA), 0);
        checkOutput("rst_busy", 32'(busyA), 0);
        checkOutput("rst_ready", 32'(dataReadyA), 0);
        checkOutput("rst_hitcnt", 32'(hitCntA), 0);
        checkOutput("rst_misscnt", 32'(missCntA), 0);
        reset = 1'b0;
        tick();

        // Read hit: COMPARE then DONE with data_ready, hit counted.
        applyStimulus(1, 0, 1, 0, 0);
        tick();
        checkOutput("rh_compare", 32'(stateA), 1);
        checkOutput("rh_busy", 32'(busyA), 1);
        applyStimulus(0, 0, 1, 0, 0);
        tick();
        checkOutput("rh_done", 32'(stateA), 5);
        checkOutput("rh_ready", 32'(dataReadyA), 1);
        tick();
        checkOutput("rh_idle", 32'(stateA), 0);
        checkOutput("rh_ready_low", 32'(dataReadyA), 0);
        checkOutput("rh_hitcnt", 32'(hitCntA), 1);

        // Write hit in write-back mode: one write strobe with set_dirty, no memory traffic.
        applyStimulus(1, 1, 1, 0, 0);
        tick();
        checkOutput("wh_compare", 32'(stateA), 1);
        applyStimulus(0, 1, 1, 0, 0);
        tick();
        checkOutput("wh_write", 32'(stateA), 2);
        checkOutput("wh_wen", 32'(writeEnA), 1);
        checkOutput("wh_dirty", 32'(setDirtyA), 1);
        checkOutput("wh_memreq", 32'(memReqA), 0);
        tick();
        checkOutput("wh_done", 32'(stateA), 5);
        checkOutput("wh_wen_low", 32'(writeEnA), 0);
        checkOutput("wh_ready", 32'(dataReadyA), 1);
        tick();
        checkOutput("wh_hitcnt", 32'(hitCntA), 2);

        // Clean read miss: fill after three ALLOCATE cycles, re-compare hits.
        applyStimulus(1, 0, 0, 0, 0);
        tick();
        checkOutput("rm_compare", 32'(stateA), 1);
        applyStimulus(0, 0, 0, 0, 0);
        tick();
        checkOutput("rm_alloc", 32'(stateA), 4);
        checkOutput("rm_memreq", 32'(memReqA), 1);
        checkOutput("rm_memwe", 32'(memWeA), 0);
        checkOutput("rm_fill_noack", 32'(fillEnA), 0);
        tick();
        tick();
        checkOutput("rm_alloc3", 32'(stateA), 4);
        applyStimulus(0, 0, 1, 0, 1);
        #1;
        checkOutput("rm_fill", 32'(fillEnA), 1);
        tick();
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("rm_recompare", 32'(stateA), 1);
        checkOutput("rm_memreq_low", 32'(memReqA), 0);
        checkOutput("rm_fill_low", 32'(fillEnA), 0);
        tick();
        checkOutput("rm_done", 32'(stateA), 5);
        tick();
        checkOutput("rm_idle", 32'(stateA), 0);
        checkOutput("rm_misscnt", 32'(missCntA), 1);
        checkOutput("rm_hitcnt", 32'(hitCntA), 2);

        // Dirty write miss: WRITEBACK, ALLOCATE with immediate acks, then WRITE.
        applyStimulus(1, 1, 0, 1, 0);
        tick();
        checkOutput("wm_compare", 32'(stateA), 1);
        applyStimulus(0, 1, 0, 1, 0);
        tick();
        checkOutput("wm_wb", 32'(stateA), 3);
        checkOutput("wm_wb_req", 32'(memReqA), 1);
        checkOutput("wm_wb_we", 32'(memWeA), 1);
        applyStimulus(0, 1, 1, 0, 1);
        tick();
        checkOutput("wm_alloc", 32'(stateA), 4);
        checkOutput("wm_alloc_we", 32'(memWeA), 0);
        checkOutput("wm_fill", 32'(fillEnA), 1);
        tick();
        checkOutput("wm_recompare", 32'(stateA), 1);
        applyStimulus(0, 1, 1, 0, 0);
        tick();
        checkOutput("wm_write", 32'(stateA), 2);
        checkOutput("wm_wen", 32'(writeEnA), 1);
        checkOutput("wm_setdirty", 32'(setDirtyA), 1);
        tick();
        checkOutput("wm_done", 32'(stateA), 5);
        tick();
        checkOutput("wm_misscnt", 32'(missCntA), 2);
        checkOutput("wm_hitcnt", 32'(hitCntA), 2);

        // Timeout: four unanswered ALLOCATE cycles, then ERROR with mem_req dropped.
        applyStimulus(1, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        tick();
        checkOutput("to_alloc", 32'(stateA), 4);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("to_wait", 32'(stateA), 4);
            checkOutput("to_wait_req", 32'(memReqA), 1);
        end
        tick();
        checkOutput("to_error", 32'(stateA), 6);
        checkOutput("to_err", 32'(errA), 1);
        checkOutput("to_req_low", 32'(memReqA), 0);
        tick();
        checkOutput("to_idle", 32'(stateA), 0);
        checkOutput("to_err_low", 32'(errA), 0);
        checkOutput("to_misscnt", 32'(missCntA), 3);

        // Three more hits make five in total; the 2-bit counter holds at 3.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 1, 0, 0);
            tick();
            applyStimulus(0, 0, 1, 0, 0);
            tick();
            tick();
        end
        checkOutput("sat_hitcnt", 32'(hitCntA), 3);

        // Clear coincident with a counted hit wins.
        applyStimulus(1, 0, 1, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 0, 0);
        clrIn = 1'b1;
        tick();
        clrIn = 1'b0;
        checkOutput("clr_state", 32'(stateA), 5);
        checkOutput("clr_hitcnt", 32'(hitCntA), 0);
        checkOutput("clr_misscnt", 32'(missCntA), 0);
        tick();

        // Reset mid-ALLOCATE acts without waiting for a clock edge.
        applyStimulus(1, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        tick();
        checkOutput("mr_alloc", 32'(stateA), 4);
        checkOutput("mr_req", 32'(memReqA), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("mr_state", 32'(stateA), 0);
        checkOutput("mr_req_low", 32'(memReqA), 0);
        checkOutput("mr_busy", 32'(busyA), 0);
        #1 reset = 1'b0;
        tick();

        // Write-through write miss: WRITE waits for the memory store, no fill.
        selB = 1'b1;
        applyStimulus(1, 1, 0, 0, 0);
        tick();
        checkOutput("wt_compare", 32'(stateB), 1);
        applyStimulus(0, 1, 0, 0, 0);
        tick();
        checkOutput("wt_write", 32'(stateB), 2);
        checkOutput("wt_wen", 32'(writeEnB), 1);
        checkOutput("wt_setdirty", 32'(setDirtyB), 0);
        checkOutput("wt_req", 32'(memReqB), 1);
        checkOutput("wt_we", 32'(memWeB), 1);
        tick();
        checkOutput("wt_wait", 32'(stateB), 2);
        checkOutput("wt_wen_low", 32'(writeEnB), 0);
        checkOutput("wt_wait_req", 32'(memReqB), 1);
        applyStimulus(0, 1, 0, 0, 1);
        #1;
        checkOutput("wt_nofill", 32'(fillEnB), 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("wt_done", 32'(stateB), 5);
        checkOutput("wt_req_low", 32'(memReqB), 0);
        checkOutput("wt_ready", 32'(dataReadyB), 1);
        tick();
        checkOutput("wt_idle", 32'(stateB), 0);
        checkOutput("wt_misscnt", 32'(missCntB), 1);

        // A miss on the re-compare after a fill aborts the request.
        applyStimulus(1, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1);
        tick();
        checkOutput("rc_alloc", 32'(stateB), 4);
        checkOutput("rc_fill", 32'(fillEnB), 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rc_recompare", 32'(stateB), 1);
        tick();
        checkOutput("rc_error", 32'(stateB), 6);
        checkOutput("rc_err", 32'(errB), 1);
        tick();
        checkOutput("rc_idle", 32'(stateB), 0);
        checkOutput("rc_misscnt", 32'(missCntB), 2);
        checkOutput("rc_hitcnt", 32'(hitCntB), 0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_fsm.md
# cache_ctrl_fsm

Parametrised cache controller state machine that sequences the cache array and the main-memory port for one CPU request at a time. It is the next-generation successor of the fixed 3-bit cache FSM. It adds a selectable write-back or write-through policy, dirty-line eviction, a valid/ack memory handshake with timeout, and saturating hit/miss statistics. It sits between the CPU request port, the external tag/valid/dirty compare logic, and the memory interface.

## Interface
Parameters:
- WRITE_BACK, 1: 1 selects write-back with write-allocate; 0 selects write-through with no-write-allocate.
- TIMEOUT, 64: number of cycles to wait for mem_ack before raising an error; 0 disables the timeout.
- CNT_W, 16: width of the hit and miss statistic counters.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high.
- run, in, 1: CPU request strobe; sampled only in IDLE.
- rw, in, 1: 0 = read, 1 = write; latched together with run.
- hit, in, 1: tag-compare result; sampled only in COMPARE.
- dirty, in, 1: victim line dirty flag; sampled only in COMPARE.
- mem_ack, in, 1: memory transfer complete.
- cnt_clr, in, 1: synchronous clear of both statistic counters.
- mem_req, out, 1: memory request.
- mem_we, out, 1: memory direction; 1 = write.
- fill_en, out, 1: one-cycle strobe that loads the fetched line into the cache.
- write_en, out, 1: one-cycle strobe that writes CPU data into the cache.
- set_dirty, out, 1: with write_en, marks the line dirty (WRITE_BACK=1 only).
- data_ready, out, 1: one-cycle request-complete pulse.
- err, out, 1: one-cycle request-aborted pulse.
- busy, out, 1: high in every state except IDLE.
- state, out, 3: current state encoding.
- hit_cnt, out, CNT_W: saturating count of requests that hit.
- miss_cnt, out, CNT_W: saturating count of requests that missed.

## Operation
- State encodings: IDLE=0, COMPARE=1, WRITE=2, WRITEBACK=3, ALLOCATE=4, DONE=5, ERROR=6. Code 7 is illegal and returns to IDLE.
- IDLE:
  - run=1 latches rw, clears the first-compare flag to "first", and moves to COMPARE.
  - run is ignored in every other state.
- COMPARE, one cycle:
  - Read hit: go to DONE.
  - Write hit: go to WRITE.
  - Miss with WRITE_BACK=1 and dirty=1: go to WRITEBACK.
  - Miss with WRITE_BACK=1 and dirty=0: go to ALLOCATE.
  - Read miss with WRITE_BACK=0: go to ALLOCATE.
  - Write miss with WRITE_BACK=0: go to WRITE (no allocate).
  - On a re-compare after a fill, a miss goes to ERROR.
- WRITEBACK: mem_req=1 and mem_we=1 until mem_ack, then go to ALLOCATE.
- ALLOCATE: mem_req=1 and mem_we=0 until mem_ack. On ack, pulse fill_en and go to COMPARE; the next compare is a re-compare.
- WRITE:
  - On entry, write_en pulses for one cycle.
  - WRITE_BACK=1: set_dirty=1 with write_en, then go to DONE next cycle.
  - WRITE_BACK=0: mem_req=1 and mem_we=1 until mem_ack, then go to DONE.
- DONE: data_ready=1 for one cycle, then go to IDLE.
- ERROR: err=1 for one cycle, then go to IDLE.
- Statistics are updated only on the first COMPARE of a request:
  - hit=1 increments hit_cnt; hit=0 increments miss_cnt.
  - Counters saturate at 2^CNT_W−1.
  - cnt_clr takes priority over an increment in the same cycle.
- Timeout counter:
  - Clears on every state change.
  - Counts each cycle that mem_req=1 and mem_ack=0.
  - Reaching TIMEOUT goes to ERROR, and mem_req drops.
- Outputs are Moore-decoded from the state, except fill_en, which is mem_ack qualified by ALLOCATE.

## Timing
- Reset values: state=IDLE, every 1-bit output 0, both counters 0, timeout counter 0. Reset acts immediately, including mid-transfer; mem_req drops asynchronously.
- Read hit: run sampled at edge N → COMPARE → data_ready high in cycle N+2.
- Write hit with WRITE_BACK=1: write_en in cycle N+2, data_ready in cycle N+3.
- mem_ack arriving in the first cycle of mem_req is legal; the transfer completes in that cycle.
- mem_ack outside WRITEBACK, ALLOCATE or WRITE-waiting is ignored.
- mem_req deasserts in the cycle after mem_ack is sampled.
- A new run is accepted on the edge after data_ready or err, i.e. once the FSM is back in IDLE.

## Structure
- Package cache_ctrl_pkg holds the state_t enum (3-bit encodings above) and the IDLE/DONE/ERROR constants.
- Sub-module sat_counter, parametrised by width with inc, clr and count ports, is instantiated twice for the statistics.
- The timeout counter is inline and $clog2(TIMEOUT+1) bits wide.

## Test plan
- Read hit: run=1, rw=0, hit=1 → states 0,1,5,0; data_ready one pulse at N+2; hit_cnt=1.
- Read miss, clean, WRITE_BACK=1: hit=0, dirty=0, mem_ack after 3 cycles, hit=1 on re-compare → states 1,4,1,5; fill_en one pulse; miss_cnt=1, hit_cnt=0.
- Write miss, dirty, WRITE_BACK=1 → states 1,3,4,1,2,5; mem_we=1 in 3 and 0 in 4; write_en and set_dirty pulse together.
- Write-through write miss (WRITE_BACK=0) → states 1,2,5; mem_req with mem_we=1 until ack; fill_en never asserted.
- Timeout: TIMEOUT=4, no mem_ack → ERROR after 4 waiting cycles; err one pulse; mem_req low in the following cycle.
- Boundaries:
  - CNT_W=2 with 5 hits → hit_cnt=3.
  - cnt_clr coincident with a hit → 0.
  - Reset asserted mid-ALLOCATE → state=0 and mem_req=0 immediately.
